// File: rtl/branch_hazard_ctrl.sv
// Branch-lane scoreboard, RAW stall, EX forwarding and timed squash window.
// Optional statistics counters are enabled by defining HAZ_BRANCH_STATS_EN.
module branch_hazard_ctrl #(
    parameter int unsigned NUM_LANES     = 3,
    parameter int unsigned SQUASH_CYCLES = 1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4:0]              dc_rs1,
    input  logic [4:0]              dc_rs2,
    input  logic [4:0]              ex_rs1,
    input  logic [4:0]              ex_rs2,
    input  logic [NUM_LANES-1:0]    iss_valid,
    input  logic [5*NUM_LANES-1:0]  iss_rd,
    input  logic [NUM_LANES-1:0]    res_valid,
    input  logic [5*NUM_LANES-1:0]  res_rd,
    input  logic [32*NUM_LANES-1:0] res_data,
    input  logic                    branch_taken,
    output logic                    stall,
    output logic                    branch_squash,
    output logic                    is_rs1_fwd,
    output logic                    is_rs2_fwd,
    output logic [31:0]             rs1_fwd_data,
    output logic [31:0]             rs2_fwd_data,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        squash_cnt
);

    typedef enum logic {
        S_IDLE,
        S_SQUASH
    } sq_state_e;

    localparam logic [2:0] SQ_RELOAD = 3'(SQUASH_CYCLES - 1);

    sq_state_e             state_q, state_d;
    logic [2:0]            sq_cnt_q, sq_cnt_d;
    logic [31:0]           busy_q, busy_d;
    logic [NUM_LANES-1:0]  iss_qual;
    logic                  dc1_res_hit, dc2_res_hit;
    logic                  hazard_rs1, hazard_rs2;

    assign branch_squash = (state_q == S_SQUASH);

    // Hazard detection and EX forwarding; the first matching lane wins.
    always_comb begin
        dc1_res_hit  = 1'b0;
        dc2_res_hit  = 1'b0;
        is_rs1_fwd   = 1'b0;
        is_rs2_fwd   = 1'b0;
        rs1_fwd_data = '0;
        rs2_fwd_data = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (res_valid[i]) begin
                if (res_rd[5*i +: 5] == dc_rs1) dc1_res_hit = 1'b1;
                if (res_rd[5*i +: 5] == dc_rs2) dc2_res_hit = 1'b1;
                if (!is_rs1_fwd && ex_rs1 != 5'd0 && res_rd[5*i +: 5] == ex_rs1) begin
                    is_rs1_fwd   = 1'b1;
                    rs1_fwd_data = res_data[32*i +: 32];
                end
                if (!is_rs2_fwd && ex_rs2 != 5'd0 && res_rd[5*i +: 5] == ex_rs2) begin
                    is_rs2_fwd   = 1'b1;
                    rs2_fwd_data = res_data[32*i +: 32];
                end
            end
        end
        hazard_rs1 = (dc_rs1 != 5'd0) && busy_q[dc_rs1] && !dc1_res_hit;
        hazard_rs2 = (dc_rs2 != 5'd0) && busy_q[dc_rs2] && !dc2_res_hit;
        stall      = (hazard_rs1 | hazard_rs2) & ~branch_squash;
    end

    // Clears are applied before sets so a same-cycle issue keeps the register busy.
    always_comb begin
        busy_d   = busy_q;
        iss_qual = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (res_valid[i]) busy_d[res_rd[5*i +: 5]] = 1'b0;
        end
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            iss_qual[i] = iss_valid[i] & ~stall & ~branch_squash;
            if (iss_qual[i]) busy_d[iss_rd[5*i +: 5]] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        state_d  = state_q;
        sq_cnt_d = sq_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (branch_taken) begin
                    state_d  = S_SQUASH;
                    sq_cnt_d = SQ_RELOAD;
                end
            end
            S_SQUASH: begin
                if (branch_taken) begin
                    sq_cnt_d = SQ_RELOAD;
                end else if (sq_cnt_q == 3'd0) begin
                    state_d = S_IDLE;
                end else begin
                    sq_cnt_d = sq_cnt_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sq_cnt_q <= '0;
            busy_q   <= '0;
        end else begin
            state_q  <= state_d;
            sq_cnt_q <= sq_cnt_d;
            busy_q   <= busy_d;
        end
    end

`ifdef HAZ_BRANCH_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;
    logic             taken_prev_q, taken_prev_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        squash_cnt_d = squash_cnt_q;
        taken_prev_d = branch_taken;
        if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (branch_taken && !taken_prev_q && squash_cnt_q != '1)
            squash_cnt_d = squash_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            squash_cnt_q <= '0;
            taken_prev_q <= 1'b0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            squash_cnt_q <= squash_cnt_d;
            taken_prev_q <= taken_prev_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign squash_cnt = squash_cnt_q;
`else
    assign stall_cnt  = '0;
    assign squash_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Scoreboard bench for branch_hazard_ctrl: a reference model queues expected
// outputs every cycle, directed scenarios add fixed expectations on top.
module tb_branch_hazard_ctrl;

    localparam int unsigned NL    = 3;
    localparam int unsigned SQC   = 2;
    localparam int unsigned CNT_W = 32;

    logic              clk;
    logic              rst;
    logic [4:0]        dc_rs1, dc_rs2, ex_rs1, ex_rs2;
    logic [NL-1:0]     iss_valid;
    logic [5*NL-1:0]   iss_rd;
    logic [NL-1:0]     res_valid;
    logic [5*NL-1:0]   res_rd;
    logic [32*NL-1:0]  res_data;
    logic              branch_taken;
    logic              stall, branch_squash, is_rs1_fwd, is_rs2_fwd;
    logic [31:0]       rs1_fwd_data, rs2_fwd_data;
    logic [CNT_W-1:0]  stall_cnt, squash_cnt;

    branch_hazard_ctrl #(
        .NUM_LANES     (NL),
        .SQUASH_CYCLES (SQC),
        .CNT_W         (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dc_rs1        (dc_rs1),
        .dc_rs2        (dc_rs2),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .iss_valid     (iss_valid),
        .iss_rd        (iss_rd),
        .res_valid     (res_valid),
        .res_rd        (res_rd),
        .res_data      (res_data),
        .branch_taken  (branch_taken),
        .stall         (stall),
        .branch_squash (branch_squash),
        .is_rs1_fwd    (is_rs1_fwd),
        .is_rs2_fwd    (is_rs2_fwd),
        .rs1_fwd_data  (rs1_fwd_data),
        .rs2_fwd_data  (rs2_fwd_data),
        .stall_cnt     (stall_cnt),
        .squash_cnt    (squash_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int SEL_STALL = 0, SEL_SQ = 1, SEL_F1 = 2, SEL_F2 = 3,
                   SEL_D1 = 4, SEL_D2 = 5, SEL_SCNT = 6, SEL_QCNT = 7;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } item_t;

    item_t sb_q[$];
    int    n_total = 0;
    int    n_bad   = 0;

    // Reference model state
    bit          m_busy[32];
    int          m_sq_left;
    logic [31:0] m_stall_cnt, m_squash_cnt;
    bit          m_prev_bt;
    bit          e_stall;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_STALL: return {31'b0, stall};
            SEL_SQ:    return {31'b0, branch_squash};
            SEL_F1:    return {31'b0, is_rs1_fwd};
            SEL_F2:    return {31'b0, is_rs2_fwd};
            SEL_D1:    return rs1_fwd_data;
            SEL_D2:    return rs2_fwd_data;
            SEL_SCNT:  return stall_cnt;
            default:   return squash_cnt;
        endcase
    endfunction

    task automatic expect_const(input string tag, input int sel, input logic [31:0] v);
        item_t it;
        it.tag = tag; it.sel = sel; it.exp = v;
        sb_q.push_back(it);
    endtask

    function automatic bit res_hit(input logic [4:0] rs);
        for (int i = 0; i < NL; i++)
            if (res_valid[i] && res_rd[5*i +: 5] == rs) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_fwd(input logic [4:0] rs, output bit f, output logic [31:0] d);
        f = 1'b0; d = '0;
        if (rs != 5'd0) begin
            for (int i = 0; i < NL; i++) begin
                if (!f && res_valid[i] && res_rd[5*i +: 5] == rs) begin
                    f = 1'b1;
                    d = res_data[32*i +: 32];
                end
            end
        end
    endtask

    task automatic model_push();
        bit h1, h2, sq, f1, f2;
        logic [31:0] d1, d2;
        sq = (m_sq_left > 0);
        h1 = (dc_rs1 != 5'd0) && m_busy[dc_rs1] && !res_hit(dc_rs1);
        h2 = (dc_rs2 != 5'd0) && m_busy[dc_rs2] && !res_hit(dc_rs2);
        e_stall = (h1 || h2) && !sq;
        model_fwd(ex_rs1, f1, d1);
        model_fwd(ex_rs2, f2, d2);
        expect_const("m_stall", SEL_STALL, {31'b0, e_stall});
        expect_const("m_squash", SEL_SQ, {31'b0, sq});
        expect_const("m_fwd1", SEL_F1, {31'b0, f1});
        expect_const("m_fwd2", SEL_F2, {31'b0, f2});
        expect_const("m_data1", SEL_D1, d1);
        expect_const("m_data2", SEL_D2, d2);
`ifdef HAZ_BRANCH_STATS_EN
        expect_const("m_stall_cnt", SEL_SCNT, m_stall_cnt);
        expect_const("m_squash_cnt", SEL_QCNT, m_squash_cnt);
`else
        expect_const("m_stall_cnt", SEL_SCNT, 32'd0);
        expect_const("m_squash_cnt", SEL_QCNT, 32'd0);
`endif
    endtask

    task automatic model_edge();
        bit sq;
        sq = (m_sq_left > 0);
        if (rst) begin
            for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
            m_sq_left = 0; m_stall_cnt = '0; m_squash_cnt = '0; m_prev_bt = 1'b0;
        end else begin
            for (int i = 0; i < NL; i++)
                if (res_valid[i]) m_busy[res_rd[5*i +: 5]] = 1'b0;
            for (int i = 0; i < NL; i++)
                if (iss_valid[i] && !e_stall && !sq && iss_rd[5*i +: 5] != 5'd0)
                    m_busy[iss_rd[5*i +: 5]] = 1'b1;
            if (e_stall) m_stall_cnt = m_stall_cnt + 1;
            if (branch_taken && !m_prev_bt) m_squash_cnt = m_squash_cnt + 1;
            m_prev_bt = branch_taken;
            if (branch_taken) m_sq_left = SQC;
            else if (m_sq_left > 0) m_sq_left = m_sq_left - 1;
        end
    endtask

    // Inputs are already driven; queue model expectations, compare at negedge, advance.
    task automatic step();
        item_t it;
        model_push();
        @(negedge clk);
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check_val(it.tag, observe(it.sel), it.exp);
        end
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dc_rs1 = '0; dc_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0;
        iss_valid = '0; iss_rd = '0; res_valid = '0; res_rd = '0; res_data = '0;
        branch_taken = 1'b0;
    endtask

    task automatic set_iss(input int lane, input logic [4:0] rd);
        iss_valid[lane]      = 1'b1;
        iss_rd[5*lane +: 5]  = rd;
    endtask

    task automatic set_res(input int lane, input logic [4:0] rd, input logic [31:0] d);
        res_valid[lane]       = 1'b1;
        res_rd[5*lane +: 5]   = rd;
        res_data[32*lane +: 32] = d;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        m_sq_left = 0; m_stall_cnt = '0; m_squash_cnt = '0; m_prev_bt = 1'b0;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        step();
        step();
        rst = 1'b0;
        expect_const("rst_stall", SEL_STALL, 32'd0);
        expect_const("rst_squash", SEL_SQ, 32'd0);
        expect_const("rst_fwd1", SEL_F1, 32'd0);
        expect_const("rst_fwd2", SEL_F2, 32'd0);
        expect_const("rst_data1", SEL_D1, 32'd0);
        step();

        // RAW on rd=5 until the result bus delivers it
        idle_inputs(); set_iss(0, 5'd5); step();
        idle_inputs(); dc_rs1 = 5'd5;
        for (int k = 0; k < 3; k++) begin
            expect_const("t1_stall_hold", SEL_STALL, 32'd1);
            step();
        end
        set_res(0, 5'd5, 32'h1234);
        expect_const("t1_stall_release", SEL_STALL, 32'd0);
        step();
        idle_inputs(); dc_rs1 = 5'd5;
        expect_const("t1_busy_cleared", SEL_STALL, 32'd0);
        step();

        // r0 is never busy
        idle_inputs(); set_iss(1, 5'd0); step();
        idle_inputs(); dc_rs2 = 5'd0;
        expect_const("t2_r0_nostall", SEL_STALL, 32'd0);
        step();

        // Two lanes hit ex_rs1; lowest lane's data is forwarded
        idle_inputs(); ex_rs1 = 5'd7;
        set_res(0, 5'd7, 32'h0000AAAA);
        set_res(2, 5'd7, 32'h0000BBBB);
        expect_const("t3_fwd1", SEL_F1, 32'd1);
        expect_const("t3_data1", SEL_D1, 32'h0000AAAA);
        expect_const("t3_fwd2_off", SEL_F2, 32'd0);
        step();

        // Taken branch opens a two-cycle squash window
        idle_inputs(); set_iss(0, 5'd9); step();
        idle_inputs(); branch_taken = 1'b1; step();
        idle_inputs(); dc_rs1 = 5'd9; set_iss(1, 5'd12);
        expect_const("t4_squash_c1", SEL_SQ, 32'd1);
        expect_const("t4_squash_overrides_stall", SEL_STALL, 32'd0);
        step();
        idle_inputs(); set_iss(2, 5'd13);
        expect_const("t4_squash_c2", SEL_SQ, 32'd1);
        step();
        idle_inputs(); dc_rs1 = 5'd9;
        expect_const("t4_squash_end", SEL_SQ, 32'd0);
        expect_const("t4_stall_after", SEL_STALL, 32'd1);
        step();
        idle_inputs(); dc_rs2 = 5'd12;
        expect_const("t4_iss_ignored12", SEL_STALL, 32'd0);
        step();
        idle_inputs(); dc_rs2 = 5'd13;
        expect_const("t4_iss_ignored13", SEL_STALL, 32'd0);
        step();
        idle_inputs(); set_res(0, 5'd9, 32'h9); step();

        // Reset mid-squash with r3 busy
        idle_inputs(); set_iss(0, 5'd3); step();
        idle_inputs(); branch_taken = 1'b1; step();
        idle_inputs(); rst = 1'b1;
        expect_const("t5_squash_before_rst", SEL_SQ, 32'd1);
        step();
        rst = 1'b0; dc_rs1 = 5'd3;
        expect_const("t5_stall_after_rst", SEL_STALL, 32'd0);
        expect_const("t5_squash_after_rst", SEL_SQ, 32'd0);
        step();

        // Statistics: 4 stall cycles and 2 taken branches from a fresh reset
        idle_inputs(); set_iss(0, 5'd6); step();
        idle_inputs(); dc_rs1 = 5'd6;
        for (int k = 0; k < 4; k++) step();
        idle_inputs(); set_res(1, 5'd6, 32'h6); step();
        for (int b = 0; b < 2; b++) begin
            idle_inputs(); branch_taken = 1'b1; step();
            idle_inputs();
            for (int k = 0; k < 3; k++) step();
        end
`ifdef HAZ_BRANCH_STATS_EN
        expect_const("t6_stall_cnt", SEL_SCNT, 32'd4);
        expect_const("t6_squash_cnt", SEL_QCNT, 32'd2);
`endif
        step();

        // Random traffic over a narrow register range to force collisions
        for (int c = 0; c < 250; c++) begin
            idle_inputs();
            for (int i = 0; i < NL; i++) begin
                iss_valid[i] = ($urandom_range(0, 2) == 0);
                iss_rd[5*i +: 5] = 5'($urandom_range(0, 7));
                res_valid[i] = ($urandom_range(0, 2) == 0);
                res_rd[5*i +: 5] = 5'($urandom_range(0, 7));
                res_data[32*i +: 32] = $urandom;
            end
            dc_rs1 = 5'($urandom_range(0, 7));
            dc_rs2 = 5'($urandom_range(0, 7));
            ex_rs1 = 5'($urandom_range(0, 7));
            ex_rs2 = 5'($urandom_range(0, 7));
            branch_taken = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
